// File: rtl/clock_time_core_if.sv
// +----------------------------------------------------------------------+
// | clock_time_core_if : button inputs and display-facing outputs         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface clock_time_core_if;
  logic        btn_mode;
  logic        btn_inc;
  logic [11:0] data_show;
  logic [2:0]  byte_status;
  logic [5:0]  seconds;
  logic [1:0]  mode;
  logic        sec_tick;

  modport master (
    output btn_mode, btn_inc,
    input  data_show, byte_status, seconds, mode, sec_tick
  );

  modport slave (
    input  btn_mode, btn_inc,
    output data_show, byte_status, seconds, mode, sec_tick
  );
endinterface

`default_nettype wire

// File: rtl/clock_time_core.sv
// +----------------------------------------------------------------------+
// | clock_time_core : h/m/s timekeeping, two-button set FSM, scan phase   |
// | Optional macro AUTO_REPEAT_EN enables held-button auto-repeat. Rev 1.0|
// +----------------------------------------------------------------------+
`default_nettype none

module clock_time_core #(
  parameter int TICK_DIV   = 1000,
  parameter int SCAN_DIV   = 16,
  parameter int REPEAT_DIV = 256
) (
  input  wire logic         clock,
  input  wire logic         reset,
  clock_time_core_if.slave  bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            btn_mode_q;
  logic            btn_inc_q;
  logic [PW-1:0]   prescaler;
  logic [4:0]      hours;
  logic [5:0]      minutes;
  logic [5:0]      seconds;
  logic            sec_tick;
  logic [2:0]      byte_status;

  logic mode_press;
  logic inc_press;
  logic inc_req;
  logic tick;
  logic tick_take;
  logic inc_hour;
  logic inc_min;
  logic leave_set;

  assign mode_press = bus.btn_mode & ~btn_mode_q;
  assign inc_press  = bus.btn_inc  & ~btn_inc_q;
  assign tick       = (prescaler == PW'(TICK_DIV - 1));

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(2 * REPEAT_DIV);

  logic          rpt_active;
  logic [RW-1:0] rpt_cnt;
  logic          rpt_fire;

  assign rpt_fire = rpt_active && bus.btn_inc && (rpt_cnt == RW'(2 * REPEAT_DIV - 1));
  assign inc_req  = inc_press | rpt_fire;

  // After the first repeat the counter reloads halfway, so later repeats come every REPEAT_DIV cycles.
  always_ff @(posedge clock) begin
    if (reset || state == RUN || mode_press || !bus.btn_inc) begin
      rpt_active <= 1'b0;
      rpt_cnt    <= '0;
    end else if (inc_press) begin
      rpt_active <= 1'b1;
      rpt_cnt    <= '0;
    end else if (rpt_active) begin
      rpt_cnt <= rpt_fire ? RW'(REPEAT_DIV) : rpt_cnt + RW'(1);
    end
  end
`else
  logic unused_repeat_div;

  assign unused_repeat_div = (REPEAT_DIV > 0);
  assign inc_req           = inc_press;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // A mode press always wins: it swallows a same-cycle tick or increment.
  always_comb begin
    state_next = state;
    tick_take  = 1'b0;
    inc_hour   = 1'b0;
    inc_min    = 1'b0;
    leave_set  = 1'b0;
    case (state)
      RUN: begin
        if (mode_press) state_next = SET_HOUR;
        else            tick_take  = tick;
      end
      SET_HOUR: begin
        if (mode_press) state_next = SET_MIN;
        else            inc_hour   = inc_req;
      end
      SET_MIN: begin
        if (mode_press) begin
          state_next = RUN;
          leave_set  = 1'b1;
        end else begin
          inc_min = inc_req;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      btn_mode_q <= 1'b1;
      btn_inc_q  <= 1'b1;
      prescaler  <= '0;
      hours      <= '0;
      minutes    <= '0;
      seconds    <= '0;
      sec_tick   <= 1'b0;
    end else begin
      btn_mode_q <= bus.btn_mode;
      btn_inc_q  <= bus.btn_inc;
      sec_tick   <= tick_take;

      if (state == RUN && !mode_press) begin
        prescaler <= tick ? '0 : prescaler + PW'(1);
      end
      if (leave_set) begin
        prescaler <= '0;
        seconds   <= '0;
      end

      if (tick_take) begin
        if (seconds == 6'd59) begin
          seconds <= '0;
          if (minutes == 6'd59) begin
            minutes <= '0;
            hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
          end else begin
            minutes <= minutes + 6'd1;
          end
        end else begin
          seconds <= seconds + 6'd1;
        end
      end

      if (inc_hour) hours   <= (hours == 5'd23)   ? 5'd0 : hours + 5'd1;
      if (inc_min)  minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
    end
  end

  generate
    if (SCAN_DIV == 1) begin : g_scan_every_cycle
      always_ff @(posedge clock) begin
        if (reset) byte_status <= '0;
        else       byte_status <= byte_status + 3'd1;
      end
    end else begin : g_scan_divided
      localparam int SW = $clog2(SCAN_DIV);
      logic [SW-1:0] scan_div;

      always_ff @(posedge clock) begin
        if (reset) begin
          scan_div    <= '0;
          byte_status <= '0;
        end else if (scan_div == SW'(SCAN_DIV - 1)) begin
          scan_div    <= '0;
          byte_status <= byte_status + 3'd1;
        end else begin
          scan_div <= scan_div + SW'(1);
        end
      end
    end
  endgenerate

  assign bus.data_show   = {1'b0, hours, minutes};
  assign bus.byte_status = byte_status;
  assign bus.seconds     = seconds;
  assign bus.mode        = state;
  assign bus.sec_tick    = sec_tick;

endmodule

`default_nettype wire

// File: tb/tb_clock_time_core.sv
// +----------------------------------------------------------------------+
// | tb_clock_time_core : directed vector table plus multi-cycle sequences |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_clock_time_core;

  localparam int NV = 30;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  clock_time_core_if bus ();

  clock_time_core #(
    .TICK_DIV   (4),
    .SCAN_DIV   (2),
    .REPEAT_DIV (4)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        bm;
    logic        bi;
    logic [11:0] data;
    logic [2:0]  bs;
    logic [5:0]  sec;
    logic [1:0]  mode;
    logic        tick;
  } vec_t;

  vec_t vecs [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press_inc();
    bus.btn_inc = 1'b1;
    step();
    bus.btn_inc = 1'b0;
    step();
  endtask

  task automatic press_mode();
    bus.btn_mode = 1'b1;
    step();
    bus.btn_mode = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   ticks;
    int   cycles;
    logic [11:0] exp_min;

    n_cmp  = 0;
    n_fail = 0;
    rst          = 1'b1;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;

    //             rst bm bi data     bs    sec   mode  tick
    vecs[0]  = '{1'b1,1'b1,1'b0,12'h000,3'd0,6'd0,2'd0,1'b0};
    vecs[1]  = '{1'b1,1'b1,1'b0,12'h000,3'd0,6'd0,2'd0,1'b0};
    vecs[2]  = '{1'b0,1'b1,1'b0,12'h000,3'd0,6'd0,2'd0,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b0,12'h000,3'd1,6'd0,2'd0,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b0,12'h000,3'd1,6'd0,2'd0,1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b0,12'h000,3'd2,6'd1,2'd0,1'b1};
    vecs[6]  = '{1'b0,1'b0,1'b0,12'h000,3'd2,6'd1,2'd0,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b0,12'h000,3'd3,6'd1,2'd0,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b0,12'h000,3'd3,6'd1,2'd0,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b0,12'h000,3'd4,6'd2,2'd0,1'b1};
    vecs[10] = '{1'b0,1'b1,1'b0,12'h000,3'd4,6'd2,2'd1,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b1,12'h040,3'd5,6'd2,2'd1,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b1,12'h040,3'd5,6'd2,2'd1,1'b0};
    vecs[13] = '{1'b0,1'b0,1'b0,12'h040,3'd6,6'd2,2'd1,1'b0};
    vecs[14] = '{1'b0,1'b1,1'b1,12'h040,3'd6,6'd2,2'd2,1'b0};
    vecs[15] = '{1'b0,1'b0,1'b0,12'h040,3'd7,6'd2,2'd2,1'b0};
    vecs[16] = '{1'b0,1'b0,1'b1,12'h041,3'd7,6'd2,2'd2,1'b0};
    vecs[17] = '{1'b0,1'b0,1'b0,12'h041,3'd0,6'd2,2'd2,1'b0};
    vecs[18] = '{1'b0,1'b1,1'b0,12'h041,3'd0,6'd0,2'd0,1'b0};
    vecs[19] = '{1'b0,1'b0,1'b0,12'h041,3'd1,6'd0,2'd0,1'b0};
    vecs[20] = '{1'b0,1'b0,1'b0,12'h041,3'd1,6'd0,2'd0,1'b0};
    vecs[21] = '{1'b0,1'b0,1'b0,12'h041,3'd2,6'd0,2'd0,1'b0};
    vecs[22] = '{1'b0,1'b0,1'b0,12'h041,3'd2,6'd1,2'd0,1'b1};
    vecs[23] = '{1'b0,1'b0,1'b1,12'h041,3'd3,6'd1,2'd0,1'b0};
    vecs[24] = '{1'b1,1'b0,1'b0,12'h000,3'd0,6'd0,2'd0,1'b0};
    vecs[25] = '{1'b0,1'b1,1'b0,12'h000,3'd0,6'd0,2'd0,1'b0};
    vecs[26] = '{1'b0,1'b0,1'b0,12'h000,3'd1,6'd0,2'd0,1'b0};
    vecs[27] = '{1'b0,1'b0,1'b0,12'h000,3'd1,6'd0,2'd0,1'b0};
    vecs[28] = '{1'b0,1'b1,1'b0,12'h000,3'd2,6'd0,2'd1,1'b0};
    vecs[29] = '{1'b0,1'b0,1'b0,12'h000,3'd2,6'd0,2'd1,1'b0};

    for (int i = 0; i < NV; i++) begin
      rst          = vecs[i].rst;
      bus.btn_mode = vecs[i].bm;
      bus.btn_inc  = vecs[i].bi;
      step();
      check($sformatf("vec[%0d] {data,bs,sec,mode,tick}", i),
            {8'h00, bus.data_show, bus.byte_status, bus.seconds, bus.mode, bus.sec_tick},
            {8'h00, vecs[i].data, vecs[i].bs, vecs[i].sec, vecs[i].mode, vecs[i].tick});
    end
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;

    // SET_HOUR at 00:00 -- walk hours through the 23->0 wrap
    for (int i = 0; i < 23; i++) press_inc();
    check("hours_at_23", {20'h0, bus.data_show}, 32'h5C0);
    press_inc();
    check("hours_wrap_to_0", {20'h0, bus.data_show}, 32'h000);
    press_inc();
    check("hours_after_25_presses", {20'h0, bus.data_show}, 32'h040);
    check("seconds_frozen_in_set", {26'h0, bus.seconds}, 32'd0);

    // Preload 23:59, checking the minute wrap does not carry into hours
    for (int i = 0; i < 22; i++) press_inc();
    press_mode();
    check("mode_set_min", {30'h0, bus.mode}, 32'd2);
    for (int i = 0; i < 59; i++) press_inc();
    check("min_at_59", {20'h0, bus.data_show}, 32'h5FB);
    press_inc();
    check("min_wrap_no_carry", {20'h0, bus.data_show}, 32'h5C0);
    for (int i = 0; i < 59; i++) press_inc();

    bus.btn_mode = 1'b1;
    step();
    bus.btn_mode = 1'b0;
    check("back_to_run_mode_sec", {24'h0, bus.mode, bus.seconds}, {24'h0, 2'd0, 6'd0});

    ticks  = 0;
    cycles = 0;
    while (ticks < 60 && cycles < 1000) begin
      step();
      cycles++;
      if (bus.sec_tick) begin
        ticks++;
        if (ticks == 1)  check("first_tick_latency", cycles, 32'd4);
        if (ticks == 59) check("tick59_time", {14'h0, bus.data_show, bus.seconds}, {14'h0, 12'h5FB, 6'd59});
        if (ticks == 60) check("tick60_rollover", {14'h0, bus.data_show, bus.seconds}, {14'h0, 12'h000, 6'd0});
      end
    end
    check("tick_count_within_budget", ticks, 32'd60);
    step();
    check("sec_tick_one_cycle", {31'h0, bus.sec_tick}, 32'd0);

    // Held increment in SET_MIN from minutes=0
    press_mode();
    press_mode();
    check("mode_set_min_again", {30'h0, bus.mode}, 32'd2);
    bus.btn_inc = 1'b1;
    for (int i = 0; i < 20; i++) step();
    bus.btn_inc = 1'b0;
    step();
`ifdef AUTO_REPEAT_EN
    exp_min = 12'h004;
`else
    exp_min = 12'h001;
`endif
    check("held_inc_minutes", {20'h0, bus.data_show}, {20'h0, exp_min});

    // Reset in SET_MIN returns everything to zero next edge
    rst = 1'b1;
    step();
    check("reset_from_set_min", {14'h0, bus.mode, bus.data_show, bus.byte_status, bus.seconds[0]},
          {14'h0, 2'd0, 12'h000, 3'd0, 1'b0});
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
